// File: rtl/alu_pkg.sv
// Shared encodings and sizing helpers for the chunked ALU adder/subtractor.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int num_chunks(input int data_size, input int chunk);
      return data_size / chunk;
   endfunction

   // Index register needs at least one bit even when there is a single chunk.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational CHUNK-bit adder built from 1-bit generate/propagate cells.
module cla_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [CHUNK:0]   c;

   assign g    = x & y;
   assign p    = x ^ y;
   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_cell
      assign c[i+1] = g[i] | (p[i] & c[i]);
   end

   assign sum   = p ^ c[CHUNK-1:0];
   assign cout  = c[CHUNK];
   // Carry into the top bit; XOR with cout gives signed overflow.
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry registered between
// chunks, with valid/ready handshakes and carry/overflow/zero flags.
module add_sub_seq
   import alu_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int CHUNK     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] result,
   output logic                 carry_out,
   output logic                 overflow,
   output logic                 zero
);

   localparam int NCHUNK = num_chunks(DATA_SIZE, CHUNK);
   localparam int IDX_W  = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [DATA_SIZE-1:0] op_a;
   logic [DATA_SIZE-1:0] op_b;
   logic                 carry;

   logic [CHUNK-1:0]     x;
   logic [CHUNK-1:0]     y;
   logic [CHUNK-1:0]     sum;
   logic                 cout;
   logic                 c_msb;
   logic [DATA_SIZE-1:0] next_result;
   int                   base;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_comb begin
      base        = int'(idx) * CHUNK;
      x           = op_a[base +: CHUNK];
      y           = op_b[base +: CHUNK];
      next_result = result;
      next_result[base +: CHUNK] = sum;
   end

   cla_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x     (x),
      .y     (y),
      .cin   (carry),
      .sum   (sum),
      .cout  (cout),
      .c_msb (c_msb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1: invert B and seed the carry.
                  op_a  <= a;
                  op_b  <= (sub == OP_ADD) ? b : ~b;
                  carry <= (sub == OP_SUB);
                  idx   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               result <= next_result;
               carry  <= cout;
               if (idx == LAST_IDX) begin
                  carry_out <= cout;
                  overflow  <= c_msb ^ cout;
                  zero      <= (next_result == '0);
                  state     <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq (DATA_SIZE=16, CHUNK=4): vector table plus
// hand-written backpressure and mid-run reset sequences.
module tb_add_sub_seq;

   localparam int DW     = 16;
   localparam int CH     = 4;
   localparam int NCHUNK = DW / CH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] a_i = '0;
   logic [DW-1:0] b_i = '0;
   logic          sub_i = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] result;
   logic          carry_out;
   logic          overflow;
   logic          zero;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   add_sub_seq #(.DATA_SIZE(DW), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .sub       (sub_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          sub;
      logic [DW-1:0] res;
      logic          c;
      logic          v;
      logic          z;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Issue one request, measure latency, check outputs, then retire it.
   task automatic apply(input vec_t v);
      int lat;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      a_i = v.a; b_i = v.b; sub_i = v.sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_i = 16'hDEAD; b_i = 16'hBEEF; sub_i = ~v.sub;
      check("in_ready_run", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(NCHUNK));
      check("result", 32'(result), 32'(v.res));
      check("carry_out", 32'(carry_out), 32'(v.c));
      check("overflow", 32'(overflow), 32'(v.v));
      check("zero", 32'(zero), 32'(v.z));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

      // Reset state
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) apply(vecs[i]);

      // Backpressure: DONE held while new requests are offered.
      begin
         vec_t bp;
         int lat;
         bp = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0};
         @(negedge clk);
         a_i = bp.a; b_i = bp.b; sub_i = bp.sub; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         check("bp_latency", 32'(lat), 32'(NCHUNK));
         a_i = 16'hFFFF; b_i = 16'hFFFF; sub_i = 1'b1;
         for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(result), 32'h3333);
            check("bp_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
         end
         // Request still asserted at the retiring edge must not be taken.
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         out_ready = 1'b0;
         check("bp_in_ready_after", 32'(in_ready), 32'd1);
         check("bp_out_valid_after", 32'(out_valid), 32'd0);
         check("bp_result_held", 32'(result), 32'h3333);
         apply('{16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0});
      end

      // Reset during RUN at idx=2.
      @(negedge clk);
      a_i = 16'h1234; b_i = 16'h1111; sub_i = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
